// File: rtl/fmlbrg_datamem_pkg.sv
// -----------------------------------------------------------------------------
// fmlbrg_datamem_pkg
//   Shared definitions for the FML bridge cache data memory:
//     - state_t            : line-fill sequencer states (IDLE=0, FILL=1)
//     - DEFAULT_BEATS      : FML beats per cache line in the default build
//     - DEFAULT_BURST_LOG  : log2 of DEFAULT_BEATS
//   Optional feature macro used by the memory files: FMLBRG_DATAMEM_PARITY_EN
// -----------------------------------------------------------------------------
package fmlbrg_datamem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int DEFAULT_BEATS     = 8;
    localparam int DEFAULT_BURST_LOG = $clog2(DEFAULT_BEATS);

endpackage : fmlbrg_datamem_pkg

// File: rtl/fmlbrg_datamem_lane.sv
// -----------------------------------------------------------------------------
// fmlbrg_datamem_lane
//   One 8-bit byte lane of the bridge data memory: a single write port and two
//   read ports whose addresses are registered, data read combinationally from
//   the registered address (1-cycle latency, write-first).
//
//   Optional macro FMLBRG_DATAMEM_PARITY_EN: each entry carries a 9th bit, the
//   even parity of the byte; perr flags a mismatch on the port B read word.
//   Without the macro no parity is stored and perr is tied low.
//
// Ports:
//   clk, rst_n  clock / async active-low reset (read address registers only)
//   we          write enable for this lane
//   wa, wd      write address / write byte
//   a, rd       port A read address / read byte
//   a2, rd2     port B read address / read byte
//   perr        port B parity mismatch for this lane
// -----------------------------------------------------------------------------
module fmlbrg_datamem_lane #(
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [depth-1:0] wa,
    input  logic [7:0]       wd,
    input  logic [depth-1:0] a,
    input  logic [depth-1:0] a2,
    output logic [7:0]       rd,
    output logic [7:0]       rd2,
    output logic             perr
);

`ifdef FMLBRG_DATAMEM_PARITY_EN
    localparam int ew = 9;
`else
    localparam int ew = 8;
`endif

    logic [ew-1:0]    mem [2**depth];
    logic [depth-1:0] a_r;
    logic [depth-1:0] a2_r;

    // NOTE: the storage array has no reset; clearing it would turn the RAM into
    // a flop bank. Only the address registers are reset.
    always_ff @(posedge clk) begin
        if (we) begin
`ifdef FMLBRG_DATAMEM_PARITY_EN
            mem[wa] <= {^wd, wd};
`else
            mem[wa] <= wd;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            a2_r <= '0;
        end else begin
            a_r  <= a;
            a2_r <= a2;
        end
    end

    // Reading from the registered address makes a same-edge write visible on
    // the following cycle (write-first) for free.
    assign rd  = mem[a_r][7:0];
    assign rd2 = mem[a2_r][7:0];

`ifdef FMLBRG_DATAMEM_PARITY_EN
    assign perr = mem[a2_r][8] ^ (^mem[a2_r][7:0]);
`else
    assign perr = 1'b0;
`endif

endmodule : fmlbrg_datamem_lane

// File: rtl/fmlbrg_datamem_fill.sv
// -----------------------------------------------------------------------------
// fmlbrg_datamem_fill
//   Byte-lane data memory for the FML bridge cache with an integrated line-fill
//   sequencer. Port A is read/write with per-byte enables, port B is read-only.
//   A fill writes one FML burst (2^burst_log beats) into line fill_line, beat
//   address auto-incrementing on each fill_stb; fill writes take priority over
//   port A writes (a_stall).
//
//   Optional macro FMLBRG_DATAMEM_PARITY_EN: per-lane even parity stored and
//   checked on port B (par_err). Without it par_err is tied low.
//
// Ports:
//   sys_clk, sys_rst_n   clock / async active-low reset
//   a, we, di, dout      port A address, byte enables, write data, read data
//   a_stall              port A write refused this cycle (hold a/we/di)
//   a2, do2              port B address / read data
//   par_err              port B parity error
//   fill_start           one-cycle pulse starting a line fill (IDLE only)
//   fill_line            line index, sampled on fill_start
//   fill_stb, fill_di    fill beat valid / data
//   fill_busy            fill in progress
//   fill_done            one-cycle pulse after the last beat is written
// -----------------------------------------------------------------------------
module fmlbrg_datamem_fill
    import fmlbrg_datamem_pkg::*;
#(
    parameter int depth     = 8,
    parameter int nbytes    = 2,
    parameter int burst_log = DEFAULT_BURST_LOG
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [depth-1:0]       a,
    input  logic [nbytes-1:0]      we,
    input  logic [8*nbytes-1:0]    di,
    output logic [8*nbytes-1:0]    dout,
    output logic                   a_stall,
    input  logic [depth-1:0]       a2,
    output logic [8*nbytes-1:0]    do2,
    output logic                   par_err,
    input  logic                   fill_start,
    input  logic [depth-burst_log-1:0] fill_line,
    input  logic                   fill_stb,
    input  logic [8*nbytes-1:0]    fill_di,
    output logic                   fill_busy,
    output logic                   fill_done
);

    localparam int lw = depth - burst_log;

    state_t               state, state_nxt;
    logic [burst_log-1:0] beat, beat_nxt;
    logic [lw-1:0]        line_r, line_nxt;
    logic                 fill_done_nxt;

    logic                 fill_wr;
    logic [depth-1:0]     wa;
    logic [8*nbytes-1:0]  wd;
    logic [nbytes-1:0]    lane_we;
    logic [nbytes-1:0]    lane_perr;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            line_r    <= '0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            line_r    <= line_nxt;
            fill_done <= fill_done_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        line_nxt      = line_r;
        fill_done_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (fill_start) begin
                    line_nxt  = fill_line;
                    beat_nxt  = '0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (fill_stb) begin
                    beat_nxt = beat + 1'b1;
                    if (&beat) begin
                        state_nxt     = IDLE;
                        fill_done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fill_busy = (state == FILL);
    assign fill_wr   = fill_busy & fill_stb;
    assign a_stall   = fill_wr & (|we);

    // ---------------------------------------------------------- write mux
    // A fill beat owns the single write port; a colliding port A write is
    // dropped here and retried by the requester because of a_stall.
    assign wa      = fill_wr ? {line_r, beat} : a;
    assign wd      = fill_wr ? fill_di : di;
    assign lane_we = fill_wr ? {nbytes{1'b1}} : we;

    // -------------------------------------------------------------- lanes
    for (genvar i = 0; i < nbytes; i++) begin : g_lanes
        fmlbrg_datamem_lane #(
            .depth (depth)
        ) u_lane (
            .clk   (sys_clk),
            .rst_n (sys_rst_n),
            .we    (lane_we[i]),
            .wa    (wa),
            .wd    (wd[8*i +: 8]),
            .a     (a),
            .a2    (a2),
            .rd    (dout[8*i +: 8]),
            .rd2   (do2[8*i +: 8]),
            .perr  (lane_perr[i])
        );
    end

    assign par_err = |lane_perr;

endmodule : fmlbrg_datamem_fill

// File: tb/tb_fmlbrg_datamem_fill.sv
// -----------------------------------------------------------------------------
// tb_fmlbrg_datamem_fill
//   Self-checking bench for fmlbrg_datamem_fill (default parameters). A word-
//   level reference model (array of words with per-byte "known" flags and a
//   count of beats written into the current fill) predicts every output.
//   Optional macro FMLBRG_DATAMEM_PARITY_EN enables the parity corruption case.
// -----------------------------------------------------------------------------
module tb_fmlbrg_datamem_fill;

    localparam int DEPTH = 8;
    localparam int NB    = 2;
    localparam int BL    = 3;
    localparam int WORDS = 2**DEPTH;
    localparam int BEATS = 2**BL;

    logic                  sys_clk;
    logic                  sys_rst_n;
    logic [DEPTH-1:0]      a;
    logic [NB-1:0]         we;
    logic [8*NB-1:0]       di;
    logic [8*NB-1:0]       dout;
    logic                  a_stall;
    logic [DEPTH-1:0]      a2;
    logic [8*NB-1:0]       do2;
    logic                  par_err;
    logic                  fill_start;
    logic [DEPTH-BL-1:0]   fill_line;
    logic                  fill_stb;
    logic [8*NB-1:0]       fill_di;
    logic                  fill_busy;
    logic                  fill_done;

    fmlbrg_datamem_fill #(
        .depth     (DEPTH),
        .nbytes    (NB),
        .burst_log (BL)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .a          (a),
        .we         (we),
        .di         (di),
        .dout       (dout),
        .a_stall    (a_stall),
        .a2         (a2),
        .do2        (do2),
        .par_err    (par_err),
        .fill_start (fill_start),
        .fill_line  (fill_line),
        .fill_stb   (fill_stb),
        .fill_di    (fill_di),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [15:0] m_mem   [WORDS];
    logic [1:0]  m_known [WORDS];
    bit          m_bad   [WORDS];   // stored word deliberately corrupted
    bit          m_busy;
    int          m_line;
    int          m_beats;           // beats already written into current line
    bit          m_done;
    int          m_a_r;
    int          m_a2_r;

    function automatic logic [15:0] byte_mask(input logic [1:0] k);
        return {{8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic compare_outputs();
        logic [15:0] mk;
        bit exp_par;
        check("fill_busy", fill_busy, m_busy);
        check("fill_done", fill_done, m_done);
        mk = byte_mask(m_known[m_a_r]);
        if (mk != 16'h0) check("dout", dout & mk, m_mem[m_a_r] & mk);
        mk = byte_mask(m_known[m_a2_r]);
        if (mk != 16'h0) check("do2", do2 & mk, m_mem[m_a2_r] & mk);
`ifdef FMLBRG_DATAMEM_PARITY_EN
        exp_par = m_bad[m_a2_r];
`else
        exp_par = 1'b0;
`endif
        check("par_err", par_err, exp_par);
    endtask

    // Inputs are already driven (just after a rising edge). Check the
    // combinational stall, advance the model by one edge, then check outputs.
    task automatic tick();
        bit busy_pre;
        int idx;
        #1;
        check("a_stall", a_stall, m_busy && fill_stb && (we != '0));
        busy_pre = m_busy;
        m_done   = 1'b0;
        if (busy_pre && fill_stb) begin
            idx = m_line * BEATS + m_beats;
            m_mem[idx]   = fill_di;
            m_known[idx] = 2'b11;
            m_bad[idx]   = 1'b0;
            m_beats++;
            if (m_beats == BEATS) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (we != '0) begin
            for (int l = 0; l < NB; l++) begin
                if (we[l]) begin
                    m_mem[a][8*l +: 8] = di[8*l +: 8];
                    m_known[a][l]      = 1'b1;
                end
            end
            m_bad[a] = 1'b0;
        end
        if (!busy_pre && fill_start) begin
            m_busy  = 1'b1;
            m_line  = int'(fill_line);
            m_beats = 0;
        end
        m_a_r  = int'(a);
        m_a2_r = int'(a2);
        @(posedge sys_clk);
        #1;
        compare_outputs();
    endtask

    // Async reset asserted between edges, held over one edge, then released.
    task automatic do_reset();
        we         = '0;
        fill_start = 1'b0;
        fill_stb   = 1'b0;
        sys_rst_n  = 1'b0;
        #1;
        check("rst_busy", fill_busy, 1'b0);
        check("rst_done", fill_done, 1'b0);
        m_busy = 1'b0;
        m_done = 1'b0;
        m_a_r  = 0;
        m_a2_r = 0;
        @(posedge sys_clk);
        #1;
        compare_outputs();
        sys_rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        we         = '0;
        fill_start = 1'b0;
        fill_stb   = 1'b0;
    endtask

    // Start a fill and send n beats (data base+i); two idle cycles after beat
    // gap_after (-1 for none). Returns right after the last beat's edge.
    task automatic fill_burst(input int line, input logic [15:0] base, input int gap_after,
                              input int n, output int done_cnt);
        done_cnt   = 0;
        we         = '0;
        fill_stb   = 1'b0;
        fill_start = 1'b1;
        fill_line  = (DEPTH-BL)'(line);
        tick();
        check("busy_after_start", fill_busy, 1'b1);
        fill_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            fill_stb = 1'b1;
            fill_di  = base + 16'(i);
            tick();
            if (fill_done) done_cnt++;
            fill_stb = 1'b0;
            if (i == gap_after) begin
                repeat (2) begin
                    tick();
                    if (fill_done) done_cnt++;
                end
            end
        end
    endtask

    task automatic read_word(input logic [7:0] addr, input logic [15:0] exp);
        idle_inputs();
        a = addr;
        tick();
        check("readback", dout, exp);
    endtask

    int done_cnt;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 2'b00;
            m_bad[i]   = 1'b0;
        end
        m_busy = 0; m_line = 0; m_beats = 0; m_done = 0; m_a_r = 0; m_a2_r = 0;
        a = '0; we = '0; di = '0; a2 = '0;
        fill_start = 1'b0; fill_line = '0; fill_stb = 1'b0; fill_di = '0;
        sys_rst_n = 1'b0;

        do_reset();
        tick();

        // Port A full and partial writes.
        a = 8'h10; we = 2'b11; di = 16'hBEEF;
        tick();
        read_word(8'h10, 16'hBEEF);
        a = 8'h10; we = 2'b01; di = 16'h1234;
        tick();
        read_word(8'h10, 16'hBE34);

        // Same-cycle write and port B read of the same word.
        a = 8'h20; we = 2'b11; di = 16'hA5A5; a2 = 8'h20;
        tick();
        check("write_first_b", do2, 16'hA5A5);
        idle_inputs();

        // Line fill with a 2-cycle gap after beat 3.
        fill_burst(3, 16'h1000, 3, BEATS, done_cnt);
        idle_inputs();
        tick();
        if (fill_done) done_cnt++;
        check("done_pulses", done_cnt, 1);
        for (int i = 0; i < BEATS; i++) read_word(8'(8'h18 + i), 16'h1000 + 16'(i));

        // Collision: fill beat with port A write -> stall, then retry.
        a = 8'h05; we = 2'b11; di = 16'h5555;
        tick();
        fill_burst(5, 16'h3000, -1, 2, done_cnt);
        a = 8'h05; we = 2'b11; di = 16'hDEAD; fill_stb = 1'b1; fill_di = 16'h3002;
        tick();
        fill_stb = 1'b0;
        tick();
        check("retry_no_stall", a_stall, 1'b0);
        read_word(8'h05, 16'hDEAD);
        for (int i = 3; i < BEATS; i++) begin
            fill_stb = 1'b1;
            fill_di  = 16'h3000 + 16'(i);
            tick();
        end
        check("collision_done", fill_done, 1'b1);
        idle_inputs();
        tick();

        // Reset after 4 beats of a refill of line 3.
        fill_burst(3, 16'h2000, -1, 4, done_cnt);
        fill_stb = 1'b1; fill_di = 16'h2004;
        do_reset();
        check("mid_reset_no_done", done_cnt, 0);
        for (int i = 0; i < BEATS; i++)
            read_word(8'(8'h18 + i), (i < 4) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i));

        // Back-to-back fills: second start in the fill_done cycle.
        fill_burst(7, 16'h4000, -1, BEATS, done_cnt);
        check("b2b_done", fill_done, 1'b1);
        fill_burst(8, 16'h5000, 1, BEATS, done_cnt);
        idle_inputs();
        tick();
        read_word(8'h38, 16'h4000);
        read_word(8'h47, 16'h5007);

`ifdef FMLBRG_DATAMEM_PARITY_EN
        a = 8'h30; we = 2'b11; di = 16'h1234;
        tick();
        idle_inputs();
        a2 = 8'h30;
        tick();
        check("par_clean", par_err, 1'b0);
        dut.g_lanes[1].u_lane.mem[8'h30] = dut.g_lanes[1].u_lane.mem[8'h30] ^ 9'h001;
        m_mem[8'h30] = m_mem[8'h30] ^ 16'h0100;
        m_bad[8'h30] = 1'b1;
        tick();
        check("par_flip", par_err, 1'b1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            a          = 8'($urandom);
            a2         = 8'($urandom);
            we         = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            di         = 16'($urandom);
            fill_start = ($urandom_range(0, 15) == 0);
            fill_line  = (DEPTH-BL)'($urandom);
            fill_stb   = ($urandom_range(0, 2) != 0);
            fill_di    = 16'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fmlbrg_datamem_fill
